// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline controller
package pipe_ctrl_pkg;

   localparam int STALL_W = 6;
   localparam int PC_W    = 64;

   localparam int STG_PC  = 0;
   localparam int STG_IF  = 1;
   localparam int STG_ID  = 2;
   localparam int STG_EX  = 3;
   localparam int STG_MEM = 4;
   localparam int STG_WB  = 5;

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_TRAP_PEND = 2'd1,
      ST_FLUSH     = 2'd2
   } ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_stall_encoder.sv
// rtl/pipe_ctrl_stall_encoder.sv - maps per-stage stall requests to a hold vector
// The deepest requesting stage holds itself and every stage upstream of it.
module stall_encoder
   import pipe_ctrl_pkg::*;
(
   input  logic               req_if,
   input  logic               req_id,
   input  logic               req_ex,
   input  logic               req_mem,
   output logic [STALL_W-1:0] stall
);

   always_comb begin
      stall = '0;
      if (req_mem) begin
         stall = 6'b011111;
      end else if (req_ex) begin
         stall = 6'b001111;
      end else if (req_id) begin
         stall = 6'b000111;
      end else if (req_if) begin
         stall = 6'b000011;
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller with trap redirect
// Optional performance counters enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               stallreq_if,
   input  logic               stallreq_id,
   input  logic               stallreq_ex,
   input  logic               stallreq_mem,
   input  logic               excp_req,
   input  logic [PC_W-1:0]    excp_pc,
   output logic [STALL_W-1:0] stall,
   output logic               flush,
   output logic [PC_W-1:0]    new_pc,
   output logic               ctrl_busy
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [63:0]        perf_stall_cyc,
   output logic [63:0]        perf_flush_cnt
`endif
);

   ctrl_state_t        state, state_nxt;
   logic [PC_W-1:0]    trap_pc, trap_pc_nxt;
   logic [STALL_W-1:0] run_stall;

   stall_encoder u_stall_encoder (
      .req_if  (stallreq_if),
      .req_id  (stallreq_id),
      .req_ex  (stallreq_ex),
      .req_mem (stallreq_mem),
      .stall   (run_stall)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_RUN;
         trap_pc <= '0;
      end else begin
         state   <= state_nxt;
         trap_pc <= trap_pc_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      trap_pc_nxt = trap_pc;
      stall       = '0;
      flush       = 1'b0;
      new_pc      = '0;
      ctrl_busy   = 1'b1;
      case (state)
         ST_RUN: begin
            ctrl_busy = 1'b0;
            stall     = run_stall;
            if (excp_req) begin
               trap_pc_nxt = excp_pc;
               state_nxt   = stallreq_mem ? ST_TRAP_PEND : ST_FLUSH;
            end
         end
         ST_TRAP_PEND: begin
            // MEM and everything upstream frozen until the dcache drains.
            stall = 6'b011111;
            if (!stallreq_mem) begin
               state_nxt = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            flush     = 1'b1;
            new_pc    = trap_pc;
            state_nxt = ST_RUN;
         end
         default: begin
            state_nxt = ST_RUN;
         end
      endcase
   end

`ifdef PIPE_CTRL_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_cyc <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (stall != '0) begin
            perf_stall_cyc <= perf_stall_cyc + 64'd1;
         end
         if (flush) begin
            perf_flush_cnt <= perf_flush_cnt + 64'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl
// Build with PIPE_CTRL_PERF_EN defined to also cover the perf counters.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stallreq_if = 1'b0, stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
   logic        excp_req = 1'b0;
   logic [63:0] excp_pc = '0;
   logic [5:0]  stall;
   logic        flush;
   logic [63:0] new_pc;
   logic        ctrl_busy;
`ifdef PIPE_CTRL_PERF_EN
   logic [63:0] perf_stall_cyc, perf_flush_cnt;
`endif

   int vectors = 0;
   int miscompares = 0;

   pipe_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .stallreq_if  (stallreq_if),
      .stallreq_id  (stallreq_id),
      .stallreq_ex  (stallreq_ex),
      .stallreq_mem (stallreq_mem),
      .excp_req     (excp_req),
      .excp_pc      (excp_pc),
      .stall        (stall),
      .flush        (flush),
      .new_pc       (new_pc),
      .ctrl_busy    (ctrl_busy)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .perf_stall_cyc (perf_stall_cyc),
      .perf_flush_cnt (perf_flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Model: a trap is either waiting on MEM, or due to flush this cycle.
   logic        m_wait = 1'b0;
   logic        m_flush_now = 1'b0;
   logic [63:0] m_pc = '0;
   logic [63:0] m_stall_cyc = '0;
   logic [63:0] m_flush_cnt = '0;

   function automatic logic [5:0] exp_stall();
      int k;
      if (m_flush_now) return 6'd0;
      if (m_wait) return 6'b011111;
      k = -1;
      if (stallreq_if)  k = 1;
      if (stallreq_id)  k = 2;
      if (stallreq_ex)  k = 3;
      if (stallreq_mem) k = 4;
      if (k < 0) return 6'd0;
      return 6'((1 << (k + 1)) - 1);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_wait = 1'b0;
         m_flush_now = 1'b0;
         m_pc = '0;
         m_stall_cyc = '0;
         m_flush_cnt = '0;
      end else begin
         if (exp_stall() != 6'd0) m_stall_cyc = m_stall_cyc + 64'd1;
         if (m_flush_now) m_flush_cnt = m_flush_cnt + 64'd1;
         if (m_flush_now) begin
            m_flush_now = 1'b0;
         end else if (m_wait) begin
            if (!stallreq_mem) begin
               m_wait = 1'b0;
               m_flush_now = 1'b1;
            end
         end else if (excp_req) begin
            m_pc = excp_pc;
            if (stallreq_mem) m_wait = 1'b1;
            else m_flush_now = 1'b1;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("model_stall", 64'(stall), 64'(exp_stall()));
         chk("model_flush", 64'(flush), 64'(m_flush_now));
         chk("model_new_pc", new_pc, m_flush_now ? m_pc : 64'd0);
         chk("model_busy", 64'(ctrl_busy), 64'(m_flush_now | m_wait));
`ifdef PIPE_CTRL_PERF_EN
         chk("model_perf_stall", perf_stall_cyc, m_stall_cyc);
         chk("model_perf_flush", perf_flush_cnt, m_flush_cnt);
`endif
      end
   end

   task automatic cyc(input logic [3:0] req, input logic er, input logic [63:0] pc);
      @(posedge clk);
      #1;
      {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req;
      excp_req = er;
      excp_pc  = pc;
      @(negedge clk);
      #1;
   endtask

   localparam logic [63:0] PC_A = 64'h8000_0100;
   localparam logic [63:0] PC_B = 64'h8000_0200;

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      #1;
      chk("reset_stall", 64'(stall), 64'd0);
      chk("reset_flush", 64'(flush), 64'd0);
      chk("reset_new_pc", new_pc, 64'd0);
      chk("reset_busy", 64'(ctrl_busy), 64'd0);

      cyc(4'b0010, 1'b0, '0);
      chk("id_only_stall", 64'(stall), 64'h07);
      chk("id_only_flush", 64'(flush), 64'd0);
      cyc(4'b0101, 1'b0, '0);
      chk("if_ex_stall", 64'(stall), 64'h0F);
      for (int r = 0; r < 16; r++) cyc(4'(r), 1'b0, '0);

      // Trap with MEM idle: flush on the very next cycle.
      cyc(4'b0000, 1'b1, PC_A);
      chk("accept_no_flush", 64'(flush), 64'd0);
      cyc(4'b0000, 1'b0, '0);
      chk("trap_flush", 64'(flush), 64'd1);
      chk("trap_new_pc", new_pc, PC_A);
      chk("trap_stall0", 64'(stall), 64'd0);
      cyc(4'b0000, 1'b0, '0);
      chk("post_flush", 64'(flush), 64'd0);
      chk("post_busy", 64'(ctrl_busy), 64'd0);

      // Trap behind a busy dcache; a second trap must lose.
      cyc(4'b1000, 1'b1, PC_A);
      chk("pend_accept_stall", 64'(stall), 64'h1F);
      cyc(4'b1000, 1'b1, PC_B);
      chk("pend_stall1", 64'(stall), 64'h1F);
      chk("pend_busy1", 64'(ctrl_busy), 64'd1);
      cyc(4'b1010, 1'b0, '0);
      chk("pend_stall2", 64'(stall), 64'h1F);
      cyc(4'b1000, 1'b0, '0);
      chk("pend_flush_held", 64'(flush), 64'd0);
      cyc(4'b0001, 1'b1, PC_B);
      chk("pend_release_stall", 64'(stall), 64'h1F);
      chk("pend_release_flush", 64'(flush), 64'd0);
      cyc(4'b0011, 1'b1, PC_B);
      chk("pend_flush", 64'(flush), 64'd1);
      chk("pend_first_pc_wins", new_pc, PC_A);
      chk("pend_flush_stall", 64'(stall), 64'd0);

      // Simultaneous stall and trap in RUN.
      cyc(4'b0100, 1'b1, PC_B);
      chk("run_ex_trap_stall", 64'(stall), 64'h0F);
      cyc(4'b0000, 1'b1, PC_A);
      chk("flush_ignores_excp_pc", new_pc, PC_B);
      cyc(4'b0000, 1'b0, '0);
      chk("flush_excp_ignored", 64'(flush), 64'd0);

      // Reset while a trap is pending.
      cyc(4'b1000, 1'b1, PC_A);
      cyc(4'b1000, 1'b0, '0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'b0000;
      excp_req = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_pend_stall", 64'(stall), 64'd0);
      chk("rst_pend_busy", 64'(ctrl_busy), 64'd0);
      chk("rst_pend_new_pc", new_pc, 64'd0);
`ifdef PIPE_CTRL_PERF_EN
      chk("rst_perf_stall", perf_stall_cyc, 64'd0);
      chk("rst_perf_flush", perf_flush_cnt, 64'd0);
`endif
      for (int i = 0; i < 4; i++) begin
         cyc(4'b0000, 1'b0, '0);
         chk("rst_no_flush", 64'(flush), 64'd0);
      end

      cyc(4'b0000, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0);
      cyc(4'b0000, 1'b0, '0);
      chk("max_pc_flush", new_pc, 64'hFFFF_FFFF_FFFF_FFF0);
      cyc(4'b0000, 1'b0, '0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL: clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL: stallreq_if  input  1  fetch stall request (icache miss).
REQ-004 SHALL: stallreq_id  input  1  decode stall request (load-use hazard).
REQ-005 SHALL: stallreq_ex  input  1  execute stall request (mul/div busy).
REQ-006 SHALL: stallreq_mem  input  1  memory stall request (dcache busy).
REQ-007 SHALL: excp_req  input  1  exception/trap request, level, sampled each cycle.
REQ-008 SHALL: excp_pc  input  64  trap target PC, valid with excp_req.
REQ-009 SHALL: stall  output  6  per-stage hold: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
REQ-010 SHALL: flush  output  1  one-cycle pipeline flush strobe.
REQ-011 SHALL: new_pc  output  64  redirect PC, valid while flush=1, else 0.
REQ-012 SHALL: ctrl_busy  output  1  high whenever FSM is not in RUN.

Function
REQ-013 SHALL: FSM states RUN, TRAP_PEND, FLUSH; state and latched trap PC registered.
REQ-014 SHALL: in RUN, k = highest requesting stage (if=1, id=2, ex=3, mem=4); stall[k:0]=1, stall[5:k+1]=0; no request -> stall=6'b000000 (combinational, zero latency).
REQ-015 SHALL: RUN, excp_req=1, stallreq_mem=0 -> latch excp_pc, next state FLUSH.
REQ-016 SHALL: RUN, excp_req=1, stallreq_mem=1 -> latch excp_pc, next state TRAP_PEND.
REQ-017 SHALL: TRAP_PEND: stall=6'b011111 regardless of other requests; excp_req/excp_pc ignored (first trap wins); stallreq_mem=0 -> FLUSH next cycle.
REQ-018 SHALL: FLUSH: flush=1, new_pc=latched PC, stall=6'b000000 for exactly one cycle; next state RUN unconditionally; excp_req in this cycle ignored.
REQ-019 SHALL: flush never asserted in RUN or TRAP_PEND; latency excp_req accept -> flush = 1 cycle when MEM idle.
REQ-020 SHALL: simultaneous stall requests and excp_req in RUN -> stall from REQ-014 in accept cycle, transition per REQ-015/016.

Reset
REQ-021 SHALL: rst -> state RUN, latched PC 0, stall=0, flush=0, new_pc=0, ctrl_busy=0 in the cycle after rst sampled high.
REQ-022 SHALL: rst during TRAP_PEND or FLUSH abandons the pending trap; no flush emitted after reset.

Configuration
REQ-023 SHALL: macro PIPE_CTRL_PERF_EN defined -> add outputs perf_stall_cyc (64) and perf_flush_cnt (64); stall_cyc +1 each cycle stall!=0, flush_cnt +1 each cycle flush=1; both 0 on reset, wrap modulo 2^64.
REQ-024 SHALL: macro undefined -> perf ports and counters absent; all other behaviour identical.

Structure
REQ-025 SHALL: shared package holds FSM state enum, stage-index constants (STG_PC..STG_WB), stall width 6, PC width 64.
REQ-026 SHALL: one sub-module stall_encoder (combinational request -> stall vector); FSM and perf counters in pipe_ctrl.

Verification
REQ-027 SHALL: stallreq_id=1 alone in RUN -> stall=6'b000111, flush=0.
REQ-028 SHALL: stallreq_if=1 and stallreq_ex=1 -> stall=6'b001111.
REQ-029 SHALL: excp_req=1, excp_pc=64'h8000_0100, no stalls -> next cycle flush=1, new_pc=64'h8000_0100, stall=0; following cycle flush=0, ctrl_busy=0.
REQ-030 SHALL: excp_req with stallreq_mem=1 held 3 cycles -> stall=6'b011111, ctrl_busy=1 for those cycles, flush=1 one cycle after stallreq_mem falls.
REQ-031 SHALL: second excp_req (pc 64'h8000_0200) during TRAP_PEND -> new_pc remains first PC 64'h8000_0100.
REQ-032 SHALL: rst asserted in TRAP_PEND -> all outputs 0, no flush afterward; with PIPE_CTRL_PERF_EN, counters read 0 after reset.
